adder_16b: RTL and testbench
============================

ADDER_16B -- requirements
Module: adder_16b

Interface
REQ-001 Parameter: WIDTH, default 16, operand and sum width; all values in this document assume 16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  qualifies x/y for capture this cycle.
REQ-005 Port: x  input  WIDTH  operand A, unsigned/two's-complement agnostic.
REQ-006 Port: y  input  WIDTH  operand B.
REQ-007 Port: out_valid  output  1  registered; high one cycle after an accepted operation.
REQ-008 Port: z  output  WIDTH  registered sum x+y modulo 2^WIDTH.
REQ-009 Port: sign  output  1  registered; equals z[WIDTH-1].
REQ-010 Port: zero  output  1  registered; 1 when z is all zeros.
REQ-011 Port: carry  output  1  registered; carry-out of bit WIDTH-1 of the unsigned sum.
REQ-012 Port: parity  output  1  registered; even-parity indicator, 1 when z has an even number of 1 bits (XNOR-reduce of z).
REQ-013 Port: overflow  output  1  registered; two's-complement overflow.

Function
REQ-014 On a rising clk edge with rst=0 and in_valid=1, the block SHALL compute {carry,z} = x + y (WIDTH+1-bit sum) and register z and all flags together.
REQ-015 Latency SHALL be exactly one cycle: outputs reflect operands sampled at edge N from edge N onward; out_valid=1 after edge N.
REQ-016 With rst=0 and in_valid=0, z and all flags SHALL hold their previous values and out_valid SHALL be 0 after the edge.
REQ-017 Back-to-back in_valid=1 cycles SHALL each produce a result; throughput one operation per cycle, no stalls.
REQ-018 overflow SHALL be 1 iff x[MSB]==y[MSB] and z[MSB]!=x[MSB]; 0 when operand signs differ.
REQ-019 Flags SHALL derive from the same registered sum as z; no flag may lag or lead z by a cycle.
REQ-020 Wrap-around: sum >= 2^WIDTH SHALL set carry=1 and z = low WIDTH bits; carry and overflow are independent (both, either, or neither may be set).
REQ-021 zero SHALL be set when z wraps to 0 (e.g. carry=1, z=0).
REQ-022 No combinational path from inputs to outputs.

Reset
REQ-023 When rst=1 at a rising edge, z SHALL be 0x0000 and sign, zero, carry, parity, overflow, out_valid SHALL all be 0 after that edge, regardless of in_valid.
REQ-024 rst has priority over in_valid; an operation presented in a reset cycle SHALL be discarded.
REQ-025 Outputs SHALL stay at reset values while rst is held; the first in_valid=1 edge after rst deasserts SHALL produce a normal result.
REQ-026 Before the first reset, output values are undefined; the bench SHALL apply reset before checking.

Verification
REQ-027 x=0x8FFF, y=0x8000 -> z=0x0FFF, sign=0, zero=0, carry=1, parity=1, overflow=1.
REQ-028 x=0xFFFE, y=0x0002 -> z=0x0000, sign=0, zero=1, carry=1, parity=1, overflow=0.
REQ-029 x=0xAAAA, y=0x5555 -> z=0xFFFF, sign=1, zero=0, carry=0, parity=1, overflow=0.
REQ-030 x=0x7FFF, y=0x0001 -> z=0x8000, sign=1, zero=0, carry=0, parity=0, overflow=1.
REQ-031 Hold/reset: x=0x0001, y=0x0000, in_valid=1 -> z=0x0001, parity=0, out_valid=1; next cycle in_valid=0 with new x/y -> z unchanged, out_valid=0; then rst=1 with in_valid=1 -> all outputs 0.
REQ-032 Back-to-back: the REQ-027..REQ-029 vectors on three consecutive cycles -> the three results appear on three consecutive cycles, each one cycle after its inputs.

Source files
------------

// File: rtl/adder_16b_if.sv
// Operand/result bundle for the registered adder.
// master drives operands and receives results; slave is the adder side.
interface adder_16b_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             out_valid;
   logic [WIDTH-1:0] z;
   logic             sign;
   logic             zero;
   logic             carry;
   logic             parity;
   logic             overflow;

   modport master (
      output in_valid, x, y,
      input  out_valid, z, sign, zero, carry, parity, overflow
   );

   modport slave (
      input  in_valid, x, y,
      output out_valid, z, sign, zero, carry, parity, overflow
   );
endinterface

// File: rtl/adder_16b.sv
// Single-cycle registered adder that produces the sum together with its status flags.
// Every flag comes from the same combinational sum, so all flags update on the same edge as z.
module adder_16b #(
   parameter int WIDTH = 16
) (
   input logic          clk,
   input logic          rst,
   adder_16b_if.slave   bus
);

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sum_low;
   logic             sum_ovf;

   always_comb begin
      sum     = {1'b0, bus.x} + {1'b0, bus.y};
      sum_low = sum[WIDTH-1:0];
      // Signed overflow: both operands share a sign and the result's sign differs from it.
      sum_ovf = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (sum_low[WIDTH-1] != bus.x[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.z         <= '0;
         bus.sign      <= 1'b0;
         bus.zero      <= 1'b0;
         bus.carry     <= 1'b0;
         bus.parity    <= 1'b0;
         bus.overflow  <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.z        <= sum_low;
            bus.sign     <= sum_low[WIDTH-1];
            bus.zero     <= (sum_low == '0);
            bus.carry    <= sum[WIDTH];
            bus.parity   <= ~^sum_low;
            bus.overflow <= sum_ovf;
         end
      end
   end

endmodule

// File: tb/tb_adder_16b.sv
// Self-checking bench for adder_16b: directed vectors, hold/reset behaviour and random traffic
// compared against an arithmetic reference model.
module tb_adder_16b;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   adder_16b_if #(.WIDTH(16)) bus ();

   adder_16b #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Result word: {out_valid, z[15:0], sign, zero, carry, parity, overflow}
   logic [21:0] last_exp;

   function automatic logic [21:0] observed();
      return {bus.out_valid, bus.z, bus.sign, bus.zero, bus.carry, bus.parity, bus.overflow};
   endfunction

   function automatic logic [21:0] model(input logic [15:0] a, input logic [15:0] b);
      int unsigned u;
      int          sa, sb, ss;
      logic [15:0] r;
      logic        c, ovf;
      u   = int'(a) + int'(b);
      r   = u[15:0];
      c   = (u >= 32'd65536);
      sa  = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
      sb  = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
      ss  = sa + sb;
      ovf = (ss > 32767) || (ss < -32768);
      return {1'b1, r, (r >= 16'h8000), (r == 16'h0000), c, ($countones(r) % 2 == 0), ovf};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.x = 16'($urandom);
         bus.y = 16'($urandom);
         tick();
         vectors++;
         if (observed() !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_hold[%0d]: got %h want %h", i, observed(), 22'h0);
         end
      end
      rst = 1'b0;
      bus.in_valid = 1'b0;
      last_exp = 22'h0;
   endtask

   task automatic test_directed();
      logic [15:0] xs [4] = '{16'h8FFF, 16'hFFFE, 16'hAAAA, 16'h7FFF};
      logic [15:0] ys [4] = '{16'h8000, 16'h0002, 16'h5555, 16'h0001};
      logic [21:0] want [4] = '{{1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
                                {1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
                                {1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
                                {1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.x = xs[i];
         bus.y = ys[i];
         tick();
         bus.in_valid = 1'b0;
         vectors++;
         if (observed() !== want[i]) begin
            miscompares++;
            $display("FAIL directed[%0d] %h+%h: got %h want %h", i, xs[i], ys[i], observed(), want[i]);
         end
         last_exp = want[i];
      end
   endtask

   task automatic test_hold_reset();
      logic [21:0] want;
      bus.in_valid = 1'b1;
      bus.x = 16'h0001;
      bus.y = 16'h0000;
      tick();
      want = {1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (observed() !== want) begin
         miscompares++;
         $display("FAIL hold_load: got %h want %h", observed(), want);
      end
      bus.in_valid = 1'b0;
      bus.x = 16'h1234;
      bus.y = 16'h4321;
      tick();
      want[21] = 1'b0;
      vectors++;
      if (observed() !== want) begin
         miscompares++;
         $display("FAIL hold_idle: got %h want %h", observed(), want);
      end
      rst = 1'b1;
      bus.in_valid = 1'b1;
      tick();
      vectors++;
      if (observed() !== 22'h0) begin
         miscompares++;
         $display("FAIL reset_discard: got %h want %h", observed(), 22'h0);
      end
      rst = 1'b0;
      bus.x = 16'h0003;
      bus.y = 16'h0004;
      tick();
      want = model(16'h0003, 16'h0004);
      vectors++;
      if (observed() !== want) begin
         miscompares++;
         $display("FAIL first_after_reset: got %h want %h", observed(), want);
      end
      bus.in_valid = 1'b0;
      last_exp = want;
   endtask

   task automatic test_back_to_back();
      logic [15:0] xs [3] = '{16'h8FFF, 16'hFFFE, 16'hAAAA};
      logic [15:0] ys [3] = '{16'h8000, 16'h0002, 16'h5555};
      logic [21:0] want [3] = '{{1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
                                {1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
                                {1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}};
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.x = xs[i];
         bus.y = ys[i];
         tick();
         vectors++;
         if (observed() !== want[i]) begin
            miscompares++;
            $display("FAIL back_to_back[%0d]: got %h want %h", i, observed(), want[i]);
         end
      end
      bus.in_valid = 1'b0;
      tick();
      vectors++;
      if (observed() !== {1'b0, want[2][20:0]}) begin
         miscompares++;
         $display("FAIL back_to_back_drain: got %h want %h", observed(), {1'b0, want[2][20:0]});
      end
      last_exp = {1'b0, want[2][20:0]};
   endtask

   task automatic test_random();
      logic [21:0] want;
      logic [15:0] a, b;
      for (int i = 0; i < 300; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         case ($urandom_range(0, 5))
            0: b = 16'(17'h10000 - {1'b0, a});
            1: a = 16'h8000;
            2: b = 16'h7FFF;
            default: ;
         endcase
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.x = a;
         bus.y = b;
         want = bus.in_valid ? model(a, b) : {1'b0, last_exp[20:0]};
         tick();
         vectors++;
         if (observed() !== want) begin
            miscompares++;
            $display("FAIL random[%0d] v=%0b %h+%h: got %h want %h", i, bus.in_valid, a, b, observed(), want);
         end
         last_exp = want;
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.x = '0;
      bus.y = '0;
      last_exp = '0;
      tick();
      test_reset();
      test_directed();
      test_hold_reset();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
